// File: rtl/sort_locate_pkg.sv
// Shared types and width helpers for the block-partitioned insertion-index locator.
// Compare direction is selected by LOCATE_DESC_EN; see sort_block_rank.
package sort_locate_pkg;

  typedef enum logic [1:0] {
    FLAG_INIT   = 2'b00,
    FLAG_LESS   = 2'b01,
    FLAG_FIT    = 2'b10,
    FLAG_LARGER = 2'b11
  } flag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  // A single-block array still needs a one-bit select.
  function automatic int unsigned sel_width(input int unsigned nblock);
    return (nblock > 1) ? $clog2(nblock) : 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned nblock,
                                            input int unsigned blk_len);
    return $clog2(nblock * blk_len + 1);
  endfunction

  function automatic int unsigned rank_width(input int unsigned blk_len);
    return $clog2(blk_len + 1);
  endfunction

endpackage

// File: rtl/sort_block_locator_if.sv
// Key in / block read / result out bundle of the insertion-index locator.
// The locator itself uses the slave modport; the key source, array and sink use master.
interface sort_block_locator_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned BLK_LEN = 10,
  parameter int unsigned NBLOCK  = 10,
  parameter int unsigned ID_W    = 4
);
  import sort_locate_pkg::*;

  localparam int unsigned IDX_W = idx_width(NBLOCK, BLK_LEN);
  localparam int unsigned SEL_W = sel_width(NBLOCK);

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_key;
  logic [ID_W-1:0]          in_id;

  logic [SEL_W-1:0]         blk_sel;
  logic [WIDTH*BLK_LEN-1:0] blk_data;

  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         out_index;
  logic [WIDTH-1:0]         out_key;
  logic [ID_W-1:0]          out_id;
  flag_t                    out_flag;

  modport slave (
    input  in_valid, in_key, in_id, blk_data, out_ready,
    output in_ready, blk_sel, out_valid, out_index, out_key, out_id, out_flag
  );

  modport master (
    output in_valid, in_key, in_id, blk_data, out_ready,
    input  in_ready, blk_sel, out_valid, out_index, out_key, out_id, out_flag
  );

endinterface

// File: rtl/sort_block_rank.sv
// Combinational rank of a key within one block: how many elements lie before it.
// Ascending by default; LOCATE_DESC_EN makes it count elements strictly greater than key.
module sort_block_rank #(
  parameter  int unsigned WIDTH   = 16,
  parameter  int unsigned BLK_LEN = 10,
  localparam int unsigned RANK_W  = $clog2(BLK_LEN + 1)
) (
  input  logic [WIDTH-1:0]         key,
  input  logic [WIDTH*BLK_LEN-1:0] blk_data,
  output logic [RANK_W-1:0]        rank
);

  always_comb begin
    rank = '0;
    for (int unsigned i = 0; i < BLK_LEN; i++) begin
`ifdef LOCATE_DESC_EN
      if (blk_data[i*WIDTH +: WIDTH] > key) rank = rank + RANK_W'(1);
`else
      if (blk_data[i*WIDTH +: WIDTH] < key) rank = rank + RANK_W'(1);
`endif
    end
  end

endmodule

// File: rtl/sort_block_locator.sv
// Sequential insertion-index locator: walks a block-partitioned sorted array one block per clock.
// Array order follows LOCATE_DESC_EN (descending when defined, ascending otherwise).
module sort_block_locator
  import sort_locate_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned BLK_LEN = 10,
  parameter int unsigned NBLOCK  = 10,
  parameter int unsigned ID_W    = 4
) (
  input logic                 clk,
  input logic                 rst,
  sort_block_locator_if.slave bus
);

  localparam int unsigned IDX_W  = idx_width(NBLOCK, BLK_LEN);
  localparam int unsigned SEL_W  = sel_width(NBLOCK);
  localparam int unsigned RANK_W = rank_width(BLK_LEN);

  localparam logic [RANK_W-1:0] FULL_RANK  = RANK_W'(BLK_LEN);
  localparam logic [SEL_W-1:0]  LAST_BLK   = SEL_W'(NBLOCK - 1);
  localparam logic [IDX_W-1:0]  FULL_INDEX = IDX_W'(NBLOCK * BLK_LEN);

  if (BLK_LEN < 2) begin : g_bad_blk_len
    $error("sort_block_locator: BLK_LEN must be at least 2");
  end
  if (NBLOCK < 1) begin : g_bad_nblock
    $error("sort_block_locator: NBLOCK must be at least 1");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  key_q, key_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [SEL_W-1:0]  blk_q, blk_d;
  logic [IDX_W-1:0]  index_q, index_d;
  flag_t             flag_q, flag_d;
  logic              valid_q, valid_d;

  logic [RANK_W-1:0] rank;
  logic [IDX_W-1:0]  fit_index;

  sort_block_rank #(
    .WIDTH  (WIDTH),
    .BLK_LEN(BLK_LEN)
  ) u_rank (
    .key     (key_q),
    .blk_data(bus.blk_data),
    .rank    (rank)
  );

  assign fit_index = IDX_W'(blk_q) * IDX_W'(BLK_LEN) + IDX_W'(rank);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    id_d    = id_q;
    blk_d   = blk_q;
    index_d = index_q;
    flag_d  = flag_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          key_d   = bus.in_key;
          id_d    = bus.in_id;
          blk_d   = '0;
          flag_d  = FLAG_INIT;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (rank == '0 && blk_q == '0) begin
          flag_d  = FLAG_LESS;
          index_d = '0;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else if (rank < FULL_RANK) begin
          // Also covers rank 0 in a later block: key sits right after the previous block.
          flag_d  = FLAG_FIT;
          index_d = fit_index;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else if (blk_q == LAST_BLK) begin
          flag_d  = FLAG_LARGER;
          index_d = FULL_INDEX;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          flag_d = FLAG_LARGER;
          blk_d  = blk_q + SEL_W'(1);
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      id_q    <= '0;
      blk_q   <= '0;
      index_q <= '0;
      flag_q  <= FLAG_INIT;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      id_q    <= id_d;
      blk_q   <= blk_d;
      index_q <= index_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.blk_sel   = blk_q;
  assign bus.out_valid = valid_q;
  assign bus.out_index = index_q;
  assign bus.out_key   = key_q;
  assign bus.out_id    = id_q;
  assign bus.out_flag  = flag_q;

  // A stalled result must not move until the sink takes it.
  hold_while_stalled : assert property (
    @(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_index) && $stable(bus.out_key) &&
       $stable(bus.out_id) && $stable(bus.out_flag))
  );

endmodule
